// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, UART
// register map and the status bits the loader cares about.
package uart_loader_pkg;

  localparam int unsigned DW      = 32;
  localparam int unsigned UART_AW = 2;
  localparam int unsigned MEM_AW  = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RXPOLL,
    ST_RXREAD,
    ST_MEMWR,
    ST_TXPOLL,
    ST_TXWR,
    ST_FINISH
  } state_e;

  typedef enum logic {
    PH_HDR,
    PH_DATA
  } phase_e;

  localparam logic [UART_AW-1:0] UART_DATA   = 2'd0;
  localparam logic [UART_AW-1:0] UART_STATUS = 2'd1;
  localparam logic [UART_AW-1:0] UART_BAUD   = 2'd2;

  localparam int unsigned REC_NEW   = 1;
  localparam int unsigned SEND_FULL = 4;

endpackage

// File: rtl/uart_loader_wbm.sv
// Single-transfer Wishbone master: latches a request, holds stb until ack,
// then pulses done_o with the captured read data.
module uart_loader_wbm
  import uart_loader_pkg::*;
#(
  parameter int unsigned AW = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [3:0]    sel_i,
  input  logic [DW-1:0] dat_i,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [3:0]    sel_o,
  output logic [DW-1:0] dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  output logic          done_o,
  output logic [DW-1:0] rdat_o
);

  logic          stb_q, we_q, done_q;
  logic [AW-1:0] adr_q;
  logic [3:0]    sel_q;
  logic [DW-1:0] dat_q, rdat_q;

  // A new request is refused while done_q is high, which guarantees an idle
  // stb cycle between back-to-back transfers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
      done_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (stb_q) begin
        if (wb_ack_i) begin
          stb_q  <= 1'b0;
          done_q <= 1'b1;
          rdat_q <= wb_dat_i;
        end
      end else if (req_i && !done_q) begin
        stb_q <= 1'b1;
        we_q  <= we_i;
        adr_q <= adr_i;
        sel_q <= sel_i;
        dat_q <= dat_i;
      end
    end
  end

  assign stb_o  = stb_q;
  assign we_o   = we_q;
  assign adr_o  = adr_q;
  assign sel_o  = sel_q;
  assign dat_o  = dat_q;
  assign done_o = done_q;
  assign rdat_o = rdat_q;

endmodule

// File: rtl/uart_loader.sv
// Boot loader: drains a length-prefixed byte frame from the UART, writes it as
// little-endian words to memory and optionally echoes an XOR checksum.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADR      = 32'h0000_0000,
  parameter bit          ECHO_CHECKSUM = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              uart_stb_o,
  output logic              uart_we_o,
  output logic [UART_AW-1:0] uart_adr_o,
  output logic [3:0]        uart_sel_o,
  output logic [DW-1:0]     uart_dat_o,
  input  logic [DW-1:0]     uart_dat_i,
  input  logic              uart_ack_i,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_adr_o,
  output logic [3:0]        mem_sel_o,
  output logic [DW-1:0]     mem_dat_o,
  input  logic              mem_ack_i
);

  localparam state_e TAIL_ST = ECHO_CHECKSUM ? ST_TXPOLL : ST_FINISH;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [1:0]  b_q, b_d;
  logic [31:0] k_q, k_d, n_q, n_d, word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic        busy_q, done_q;

  logic               u_req_c, u_we_c, u_done;
  logic [UART_AW-1:0] u_adr_c;
  logic [3:0]         u_sel_c;
  logic [DW-1:0]      u_rdat, m_rdat;
  logic               m_req_c, m_done;
  logic [31:0]        k_inc_c;
  logic               unused_rdat;

  assign k_inc_c     = k_q + 32'd1;
  assign unused_rdat = ^{u_rdat[31:8], m_rdat};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= PH_HDR;
      b_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      b_q     <= b_d;
      k_q     <= k_d;
      n_q     <= n_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_FINISH);
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    b_d     = b_q;
    k_d     = k_q;
    n_d     = n_q;
    word_d  = word_q;
    csum_d  = csum_q;
    u_req_c = 1'b0;
    u_we_c  = 1'b0;
    u_adr_c = UART_STATUS;
    u_sel_c = 4'hF;
    m_req_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          b_d     = '0;
          k_d     = '0;
          csum_d  = '0;
          phase_d = PH_HDR;
          state_d = ST_RXPOLL;
        end
      end
      ST_RXPOLL: begin
        u_req_c = 1'b1;
        if (u_done && u_rdat[REC_NEW]) state_d = ST_RXREAD;
      end
      ST_RXREAD: begin
        u_req_c = 1'b1;
        u_adr_c = UART_DATA;
        if (u_done) begin
          word_d = {u_rdat[7:0], word_q[31:8]};
          if (phase_q == PH_DATA) csum_d = csum_q ^ u_rdat[7:0];
          b_d     = b_q + 2'd1;
          state_d = ST_RXPOLL;
          if (b_q == 2'd3) begin
            if (phase_q == PH_HDR) begin
              n_d = word_d;
              if (word_d == 32'd0) state_d = TAIL_ST;
              else phase_d = PH_DATA;
            end else begin
              state_d = ST_MEMWR;
            end
          end
        end
      end
      ST_MEMWR: begin
        m_req_c = 1'b1;
        if (m_done) begin
          k_d     = k_inc_c;
          state_d = (k_inc_c == n_q) ? TAIL_ST : ST_RXPOLL;
        end
      end
      ST_TXPOLL: begin
        u_req_c = 1'b1;
        if (u_done && !u_rdat[SEND_FULL]) state_d = ST_TXWR;
      end
      ST_TXWR: begin
        u_req_c = 1'b1;
        u_we_c  = 1'b1;
        u_adr_c = UART_DATA;
        u_sel_c = 4'b0001;
        if (u_done) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  uart_loader_wbm #(.AW(UART_AW)) u_uart_wbm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (u_req_c),
    .we_i     (u_we_c),
    .adr_i    (u_adr_c),
    .sel_i    (u_sel_c),
    .dat_i    ({24'd0, csum_q}),
    .stb_o    (uart_stb_o),
    .we_o     (uart_we_o),
    .adr_o    (uart_adr_o),
    .sel_o    (uart_sel_o),
    .dat_o    (uart_dat_o),
    .wb_dat_i (uart_dat_i),
    .wb_ack_i (uart_ack_i),
    .done_o   (u_done),
    .rdat_o   (u_rdat)
  );

  // Word address wraps modulo 2^30 by construction of the 30-bit add.
  uart_loader_wbm #(.AW(MEM_AW)) u_mem_wbm (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (m_req_c),
    .we_i     (1'b1),
    .adr_i    (BASE_ADR[31:2] + k_q[MEM_AW-1:0]),
    .sel_i    (4'hF),
    .dat_i    (word_q),
    .stb_o    (mem_stb_o),
    .we_o     (mem_we_o),
    .adr_o    (mem_adr_o),
    .sel_o    (mem_sel_o),
    .dat_o    (mem_dat_o),
    .wb_dat_i (32'd0),
    .wb_ack_i (mem_ack_i),
    .done_o   (m_done),
    .rdat_o   (m_rdat)
  );

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: one echoing instance at BASE_ADR 0x100 and
// one non-echoing instance, each with a behavioural UART and memory slave.
module tb_uart_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: BASE_ADR = 0x100, checksum echo on
  logic        start_a = 1'b0;
  logic        busy_a, done_a;
  logic        ua_stb, ua_we;
  logic [1:0]  ua_adr;
  logic [3:0]  ua_sel;
  logic [31:0] ua_dout;
  logic [31:0] ua_din = 32'd0;
  logic        ua_ack = 1'b0;
  logic        ma_stb, ma_we;
  logic [29:0] ma_adr;
  logic [3:0]  ma_sel;
  logic [31:0] ma_dout;
  logic        ma_ack = 1'b0;

  uart_loader #(.BASE_ADR(32'h0000_0100), .ECHO_CHECKSUM(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .uart_stb_o(ua_stb), .uart_we_o(ua_we), .uart_adr_o(ua_adr), .uart_sel_o(ua_sel),
    .uart_dat_o(ua_dout), .uart_dat_i(ua_din), .uart_ack_i(ua_ack),
    .mem_stb_o(ma_stb), .mem_we_o(ma_we), .mem_adr_o(ma_adr), .mem_sel_o(ma_sel),
    .mem_dat_o(ma_dout), .mem_ack_i(ma_ack)
  );

  // Instance B: BASE_ADR = 0, no checksum echo
  logic        start_b = 1'b0;
  logic        busy_b, done_b;
  logic        ub_stb, ub_we;
  logic [1:0]  ub_adr;
  logic [3:0]  ub_sel;
  logic [31:0] ub_dout;
  logic [31:0] ub_din = 32'd0;
  logic        ub_ack = 1'b0;
  logic        mb_stb, mb_we;
  logic [29:0] mb_adr;
  logic [3:0]  mb_sel;
  logic [31:0] mb_dout;
  logic        mb_ack = 1'b0;

  uart_loader #(.BASE_ADR(32'h0000_0000), .ECHO_CHECKSUM(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .uart_stb_o(ub_stb), .uart_we_o(ub_we), .uart_adr_o(ub_adr), .uart_sel_o(ub_sel),
    .uart_dat_o(ub_dout), .uart_dat_i(ub_din), .uart_ack_i(ub_ack),
    .mem_stb_o(mb_stb), .mem_we_o(mb_we), .mem_adr_o(mb_adr), .mem_sel_o(mb_sel),
    .mem_dat_o(mb_dout), .mem_ack_i(mb_ack)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Slave-side bookkeeping for A
  logic [7:0]  rxq[$];
  logic [29:0] mw_adr[$];
  logic [31:0] mw_dat[$];
  int st_cnt = 0, st_rx_cnt = 0, st_tx_cnt = 0, dr_cnt = 0;
  int nopoll_until = 0, full_until = 0, mem_delay = 0;
  int uw_cnt = 0, bad_read = 0, gap_err = 0, stab_err = 0, tx_early = 0, mw_bad = 0;
  int m_wait = 0, last_stall = 0, done_a_cnt = 0;
  logic [31:0] uw_dat = 32'd0;
  logic [3:0]  uw_sel = 4'd0;
  logic        rec_ok = 1'b0, sf_last = 1'b0, rn, sf;
  logic [67:0] m_snap = '0;

  // Slave-side bookkeeping for B
  logic [7:0] rxq_b[$];
  int b_uw_cnt = 0, b_mw_cnt = 0, done_b_cnt = 0;
  logic [31:0] b_mw_dat = 32'd0;
  logic [29:0] b_mw_adr = 30'd0;

  always @(posedge clk) begin
    if (done_a) done_a_cnt <= done_a_cnt + 1;
    if (done_b) done_b_cnt <= done_b_cnt + 1;
  end

  // A's slaves: UART acks immediately, memory after mem_delay stall cycles
  always @(negedge clk) begin
    if (rst) begin
      ua_ack = 1'b0; ma_ack = 1'b0; m_wait = 0; rec_ok = 1'b0; sf_last = 1'b0;
    end else begin
      if (ua_ack) begin
        ua_ack = 1'b0;
        if (ua_stb) gap_err++;
      end else if (ua_stb) begin
        ua_ack = 1'b1;
        if (ua_we) begin
          uw_cnt++; uw_dat = ua_dout; uw_sel = ua_sel;
          if (sf_last) tx_early++;
        end else if (ua_adr == 2'd1) begin
          st_cnt++;
          if (rxq.size() > 0) begin
            rn = (st_rx_cnt >= nopoll_until);
            sf = 1'b0;
            st_rx_cnt++;
          end else begin
            rn = 1'b0;
            sf = (st_tx_cnt < full_until);
            st_tx_cnt++;
          end
          rec_ok = rn; sf_last = sf;
          ua_din = {27'd0, sf, 2'd0, rn, 1'b0};
        end else begin
          dr_cnt++;
          if (!rec_ok || rxq.size() == 0) bad_read++;
          else ua_din = {24'hA5A5A5, rxq.pop_front()};
          rec_ok = 1'b0;
        end
      end
      if (ma_ack) begin
        ma_ack = 1'b0; m_wait = 0;
        if (ma_stb) gap_err++;
      end else if (ma_stb) begin
        if (m_wait == 0) m_snap = {ma_we, ma_adr, ma_sel, ma_dout, 1'b0};
        else if ({ma_we, ma_adr, ma_sel, ma_dout, 1'b0} !== m_snap) stab_err++;
        if (m_wait >= mem_delay) begin
          ma_ack = 1'b1; last_stall = m_wait + 1;
          mw_adr.push_back(ma_adr); mw_dat.push_back(ma_dout);
          if (ma_sel !== 4'hF || ma_we !== 1'b1) mw_bad++;
        end
        m_wait++;
      end
    end
  end

  // B's slaves: data always available, never full, zero-wait acks
  always @(negedge clk) begin
    if (rst) begin
      ub_ack = 1'b0; mb_ack = 1'b0;
    end else begin
      if (ub_ack) ub_ack = 1'b0;
      else if (ub_stb) begin
        ub_ack = 1'b1;
        if (ub_we) b_uw_cnt++;
        else if (ub_adr == 2'd1) ub_din = 32'h0000_0002;
        else ub_din = {24'd0, (rxq_b.size() > 0) ? rxq_b.pop_front() : 8'h00};
      end
      if (mb_ack) mb_ack = 1'b0;
      else if (mb_stb) begin
        mb_ack = 1'b1; b_mw_cnt++; b_mw_dat = mb_dout; b_mw_adr = mb_adr;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rxq.push_back(8'(w >> (8 * i)));
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; step(); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int base;
    base = done_a_cnt;
    for (int i = 0; i < 5000 && done_a_cnt == base; i++) step();
    chk(tag, 64'(done_a_cnt - base), 64'd1);
    chk({tag, "_busy_low"}, 64'(busy_a), 64'd0);
  endtask

  initial begin
    int base;
    repeat (3) step();
    chk("rst_uart_a", 64'({busy_a, done_a, ua_stb, ua_we, ua_adr, ua_sel, ua_dout}), 64'd0);
    chk("rst_mem_a", 64'({ma_stb, ma_we, ma_adr, ma_sel}), 64'd0);
    chk("rst_memdat_a", 64'(ma_dout), 64'd0);
    rst = 1'b0;
    step();

    // Basic two-word load
    push_word(32'd2); push_word(32'h1234_5678); push_word(32'hDEAD_BEEF);
    pulse_start_a();
    chk("busy_after_start", 64'(busy_a), 64'd1);
    wait_done_a("basic_done");
    chk("basic_nwords", 64'(mw_adr.size()), 64'd2);
    if (mw_adr.size() == 2) begin
      chk("basic_adr0", 64'(mw_adr[0]), 64'h40);
      chk("basic_dat0", 64'(mw_dat[0]), 64'h1234_5678);
      chk("basic_adr1", 64'(mw_adr[1]), 64'h41);
      chk("basic_dat1", 64'(mw_dat[1]), 64'hDEAD_BEEF);
    end
    chk("basic_uart_writes", 64'(uw_cnt), 64'd1);
    chk("basic_csum", 64'(uw_dat), 64'h2A);
    chk("basic_csum_sel", 64'(uw_sel), 64'h1);
    mw_adr.delete(); mw_dat.delete();

    // Zero-length frame
    push_word(32'd0);
    pulse_start_a();
    wait_done_a("n0_done");
    chk("n0_no_mem", 64'(mw_adr.size()), 64'd0);
    chk("n0_uart_writes", 64'(uw_cnt), 64'd2);
    chk("n0_csum", 64'(uw_dat), 64'h00);

    // 20 empty polls before the first byte
    nopoll_until = st_rx_cnt + 20;
    base = st_cnt;
    push_word(32'd1); push_word(32'h4433_2211);
    pulse_start_a();
    wait_done_a("poll_done");
    chk("poll_status_reads", 64'(st_cnt - base), 64'd29);
    chk("poll_bad_reads", 64'(bad_read), 64'd0);
    chk("poll_nwords", 64'(mw_adr.size()), 64'd1);
    if (mw_adr.size() == 1) begin
      chk("poll_adr", 64'(mw_adr[0]), 64'h40);
      chk("poll_dat", 64'(mw_dat[0]), 64'h4433_2211);
    end
    chk("poll_csum", 64'(uw_dat), 64'h44);
    mw_adr.delete(); mw_dat.delete();

    // Stalled memory ack and sendFull for three TX polls
    mem_delay = 5;
    full_until = st_tx_cnt + 3;
    base = st_tx_cnt;
    push_word(32'd1); push_word(32'h0804_0201);
    pulse_start_a();
    wait_done_a("stall_done");
    chk("stall_stable", 64'(stab_err), 64'd0);
    chk("stall_len", 64'(last_stall), 64'd6);
    chk("stall_tx_polls", 64'(st_tx_cnt - base), 64'd4);
    chk("stall_tx_early", 64'(tx_early), 64'd0);
    chk("stall_csum", 64'(uw_dat), 64'h0F);
    chk("stall_dat", 64'(mw_dat.size() == 1 ? mw_dat[0] : 32'hx), 64'h0804_0201);
    mw_adr.delete(); mw_dat.delete();
    mem_delay = 0;

    // Reset after the second payload byte
    push_word(32'd2); push_word(32'h7766_C35A); push_word(32'h1111_1111);
    base = dr_cnt;
    pulse_start_a();
    for (int i = 0; i < 2000 && dr_cnt < base + 6; i++) step();
    chk("mid_reached", 64'(dr_cnt - base), 64'd6);
    rst = 1'b1;
    step();
    chk("mid_rst_uart", 64'({busy_a, done_a, ua_stb, ua_we, ua_adr, ua_sel, ua_dout}), 64'd0);
    chk("mid_rst_mem", 64'({ma_stb, ma_we, ma_adr, ma_sel}), 64'd0);
    chk("mid_rst_memdat", 64'(ma_dout), 64'd0);
    rst = 1'b0;
    rxq.delete();
    step();
    chk("mid_no_partial", 64'(mw_adr.size()), 64'd0);
    push_word(32'd1); push_word(32'h4030_2010);
    pulse_start_a();
    wait_done_a("reload_done");
    chk("reload_adr", 64'(mw_adr.size() == 1 ? mw_adr[0] : 30'hx), 64'h40);
    chk("reload_dat", 64'(mw_dat.size() == 1 ? mw_dat[0] : 32'hx), 64'h4030_2010);
    chk("reload_csum", 64'(uw_dat), 64'h40);
    chk("a_gap", 64'(gap_err), 64'd0);
    chk("a_mem_sel_we", 64'(mw_bad), 64'd0);

    // B: no echo, second start while busy is ignored
    for (int i = 0; i < 4; i++) rxq_b.push_back(8'(32'd1 >> (8 * i)));
    for (int i = 0; i < 4; i++) rxq_b.push_back(8'(32'hCAFE_F00D >> (8 * i)));
    start_b = 1'b1; step(); start_b = 1'b0;
    repeat (3) step();
    chk("b_busy", 64'(busy_b), 64'd1);
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int i = 0; i < 2000 && done_b_cnt == 0; i++) step();
    repeat (40) step();
    chk("b_done_once", 64'(done_b_cnt), 64'd1);
    chk("b_idle", 64'(busy_b), 64'd0);
    chk("b_no_uart_writes", 64'(b_uw_cnt), 64'd0);
    chk("b_mem_writes", 64'(b_mw_cnt), 64'd1);
    chk("b_mem_dat", 64'(b_mw_dat), 64'hCAFE_F00D);
    chk("b_mem_adr", 64'(b_mw_adr), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
